// File: rtl/mmsa_ctrl.sv
// mmsa_ctrl - sequencing controller for the matrix-multiplication systolic array.
//
// Deserializes the bit-serial matrix stream (16 input + 16 weight matrices of
// 16-bit elements) into the matrix SRAM, captures the 4-bit serial index pair
// of each round, streams the selected weight matrix and then the selected
// input matrix out of the SRAM, and hands the finished result to the output
// serializer. After 16 rounds the controller returns to IDLE.
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   in_valid, matrix      serial matrix stream (MSB first)
//   matrix_size           size code, sampled on the first in_valid cycle
//   in_valid2             high for the 4 index-bit cycles of a round
//   i_mat_idx, w_mat_idx  serial input / weight matrix index (MSB first)
//   mem_we, mem_re        SRAM write / read strobes (mutually exclusive)
//   mem_addr              SRAM address {bank, idx[3:0], elem[5:0]}
//   mem_wdata             assembled element being written
//   sa_size               registered size code for the array (3 clamped to 2)
//   sa_w_vld, sa_i_vld    SRAM read data is a weight / input element
//   sa_done               array result ready (one-cycle pulse)
//   out_start             start pulse to the output serializer
//   out_done              serializer finished (one-cycle pulse)
//   busy                  controller is outside IDLE
module mmsa_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        matrix,
    input  logic [1:0]  matrix_size,
    input  logic        in_valid2,
    input  logic        i_mat_idx,
    input  logic        w_mat_idx,
    output logic        mem_we,
    output logic        mem_re,
    output logic [10:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  sa_size,
    output logic        sa_w_vld,
    output logic        sa_i_vld,
    input  logic        sa_done,
    output logic        out_start,
    input  logic        out_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT2 = 3'd2,
        ST_IDX   = 3'd3,
        ST_RD_W  = 3'd4,
        ST_RD_I  = 3'd5,
        ST_COMP  = 3'd6,
        ST_OUT   = 3'd7
    } state_t;

    // Index of the last element of a matrix (N-1) for a given size code.
    function automatic logic [5:0] elem_last(input logic [1:0] sz);
        logic [5:0] r;
        case (sz)
            2'd0:    r = 6'd3;
            2'd1:    r = 6'd15;
            default: r = 6'd63;
        endcase
        return r;
    endfunction

    state_t      state_r;
    logic [15:0] shift_r;
    logic [3:0]  bit_cnt_r;
    logic [5:0]  elem_cnt_r;
    logic [4:0]  mat_cnt_r;
    logic [3:0]  i_idx_r;
    logic [3:0]  w_idx_r;
    logic [1:0]  idx_cnt_r;
    logic [5:0]  rd_cnt_r;
    logic [4:0]  round_r;

    logic [5:0]  last_elem_s;
    logic [15:0] word_s;
    logic [3:0]  i_idx_nxt_s;
    logic [3:0]  w_idx_nxt_s;

    // Element that completes when the current serial bit is shifted in, and
    // the index values after shifting in the current index bits.
    always_comb begin
        last_elem_s = elem_last(sa_size);
        word_s      = {shift_r[14:0], matrix};
        i_idx_nxt_s = {i_idx_r[2:0], i_mat_idx};
        w_idx_nxt_s = {w_idx_r[2:0], w_mat_idx};
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= 16'd0;
            bit_cnt_r  <= 4'd0;
            elem_cnt_r <= 6'd0;
            mat_cnt_r  <= 5'd0;
            i_idx_r    <= 4'd0;
            w_idx_r    <= 4'd0;
            idx_cnt_r  <= 2'd0;
            rd_cnt_r   <= 6'd0;
            round_r    <= 5'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= 11'd0;
            mem_wdata  <= 16'd0;
            sa_size    <= 2'd0;
            sa_w_vld   <= 1'b0;
            sa_i_vld   <= 1'b0;
            out_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            out_start <= 1'b0;
            // Read data returns one cycle after the strobe; the state at
            // strobe time tells whether it is a weight or an input element.
            sa_w_vld  <= mem_re && (state_r == ST_RD_W);
            sa_i_vld  <= mem_re && (state_r == ST_RD_I);

            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        // The first in_valid cycle already carries bit 15 of element 0.
                        sa_size    <= (matrix_size == 2'd3) ? 2'd2 : matrix_size;
                        shift_r    <= {15'd0, matrix};
                        bit_cnt_r  <= 4'd1;
                        elem_cnt_r <= 6'd0;
                        mat_cnt_r  <= 5'd0;
                        state_r    <= ST_LOAD;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (in_valid) begin
                        shift_r   <= word_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd15) begin
                            // mat[4] selects the weight bank, mat[3:0] is the index.
                            mem_we    <= 1'b1;
                            mem_wdata <= word_s;
                            mem_addr  <= {mat_cnt_r, elem_cnt_r};
                            if (elem_cnt_r == last_elem_s) begin
                                elem_cnt_r <= 6'd0;
                                mat_cnt_r  <= mat_cnt_r + 5'd1;
                                if (mat_cnt_r == 5'd31) begin
                                    state_r <= ST_WAIT2;
                                end
                            end else begin
                                elem_cnt_r <= elem_cnt_r + 6'd1;
                            end
                        end
                    end else begin
                        // Stream ended early: drop the partial element and start over.
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                        shift_r    <= 16'd0;
                        bit_cnt_r  <= 4'd0;
                        elem_cnt_r <= 6'd0;
                        mat_cnt_r  <= 5'd0;
                        round_r    <= 5'd0;
                    end
                end

                ST_WAIT2: begin
                    if (in_valid2) begin
                        i_idx_r   <= {3'd0, i_mat_idx};
                        w_idx_r   <= {3'd0, w_mat_idx};
                        idx_cnt_r <= 2'd0;
                        state_r   <= ST_IDX;
                    end
                end

                ST_IDX: begin
                    i_idx_r   <= i_idx_nxt_s;
                    w_idx_r   <= w_idx_nxt_s;
                    idx_cnt_r <= idx_cnt_r + 2'd1;
                    if (idx_cnt_r == 2'd2) begin
                        // First weight read goes out right after the last index bit.
                        state_r  <= ST_RD_W;
                        rd_cnt_r <= 6'd0;
                        mem_re   <= 1'b1;
                        mem_addr <= {1'b1, w_idx_nxt_s, 6'd0};
                    end
                end

                ST_RD_W: begin
                    mem_re <= 1'b1;
                    if (rd_cnt_r == last_elem_s) begin
                        state_r  <= ST_RD_I;
                        rd_cnt_r <= 6'd0;
                        mem_addr <= {1'b0, i_idx_r, 6'd0};
                    end else begin
                        rd_cnt_r <= rd_cnt_r + 6'd1;
                        mem_addr <= {1'b1, w_idx_r, rd_cnt_r + 6'd1};
                    end
                end

                ST_RD_I: begin
                    if (rd_cnt_r == last_elem_s) begin
                        state_r <= ST_COMP;
                    end else begin
                        mem_re   <= 1'b1;
                        rd_cnt_r <= rd_cnt_r + 6'd1;
                        mem_addr <= {1'b0, i_idx_r, rd_cnt_r + 6'd1};
                    end
                end

                ST_COMP: begin
                    if (sa_done) begin
                        state_r   <= ST_OUT;
                        out_start <= 1'b1;
                    end
                end

                ST_OUT: begin
                    if (out_done) begin
                        if (round_r == 5'd15) begin
                            round_r <= 5'd0;
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            round_r <= round_r + 5'd1;
                            state_r <= ST_WAIT2;
                        end
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
